fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Instruction fetch/issue sequencer. Presents an address to a synchronous
//   instruction RAM, decodes the returned word, resolves control transfers
//   (JMP, JMPZ, END) locally and issues every other instruction to the
//   datapath, waiting for its completion pulse before fetching the next one.
//   Any attempt to leave the valid address range stops the sequencer with
//   fault raised.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   instr_in   in  20  instruction word, valid one cycle after PC is presented
//   z_flag     in   1  datapath zero flag, consulted by JMPZ
//   exec_done  in   1  one-cycle pulse: the issued instruction has completed
//   PC         out  7  instruction address to the RAM
//   ir_out     out 20  instruction issued to the datapath
//   ir_valid   out  1  ir_out holds an instruction awaiting exec_done
//   halted     out  1  END executed, sequencer stopped
//   fault      out  1  sequencer stopped on an out-of-range address
module fetch_ctrl #(
  parameter int PC_MAX = 44
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] instr_in,
  input  logic        z_flag,
  input  logic        exec_done,
  output logic [6:0]  PC,
  output logic [19:0] ir_out,
  output logic        ir_valid,
  output logic        halted,
  output logic        fault
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] LATCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JMPZ = 4'hB;
  localparam logic [3:0] OP_END  = 4'hE;

  localparam logic [6:0] PC_LAST = 7'(PC_MAX);

  logic [1:0]  r_state;
  logic [6:0]  r_pc;
  logic [19:0] r_ir;
  logic        r_irValid;
  logic        r_halted;
  logic        r_fault;

  logic [1:0]  w_stateNext;
  logic [6:0]  w_pcNext;
  logic [19:0] w_irNext;
  logic        w_irValidNext;
  logic        w_haltedNext;
  logic        w_faultNext;

  logic [3:0]  w_opcode;
  logic [6:0]  w_target;
  logic        w_targetBad;
  logic        w_pcAtLast;
  logic        w_takeJump;

  // Decode fields of the word returned by the RAM. Only meaningful in LATCH,
  // which is the one cycle where instr_in corresponds to the current PC.
  assign w_opcode    = instr_in[19:16];
  assign w_target    = {1'b0, instr_in[15:10]};
  assign w_targetBad = (w_target > PC_LAST);
  assign w_pcAtLast  = (r_pc == PC_LAST);
  assign w_takeJump  = (w_opcode == OP_JMP) || ((w_opcode == OP_JMPZ) && z_flag);

  // Next-state logic. Every register holds by default, so HALT is absorbing
  // simply by having no transitions out of it. Both control-transfer and
  // sequential advance refuse to leave the valid range: instead of moving PC
  // they stop in HALT with fault set and PC left where it was.
  always_comb begin
    w_stateNext   = r_state;
    w_pcNext      = r_pc;
    w_irNext      = r_ir;
    w_irValidNext = r_irValid;
    w_haltedNext  = r_halted;
    w_faultNext   = r_fault;

    case (r_state)
      FETCH: begin
        w_stateNext = LATCH;
      end

      LATCH: begin
        if (w_takeJump) begin
          if (w_targetBad) begin
            w_stateNext = HALT;
            w_faultNext = 1'b1;
          end else begin
            w_pcNext    = w_target;
            w_stateNext = FETCH;
          end
        end else if (w_opcode == OP_JMPZ) begin
          if (w_pcAtLast) begin
            w_stateNext = HALT;
            w_faultNext = 1'b1;
          end else begin
            w_pcNext    = r_pc + 7'd1;
            w_stateNext = FETCH;
          end
        end else if (w_opcode == OP_END) begin
          w_stateNext  = HALT;
          w_haltedNext = 1'b1;
        end else begin
          w_irNext      = instr_in;
          w_irValidNext = 1'b1;
          w_stateNext   = EXEC;
        end
      end

      EXEC: begin
        if (exec_done) begin
          w_irValidNext = 1'b0;
          if (w_pcAtLast) begin
            w_stateNext = HALT;
            w_faultNext = 1'b1;
          end else begin
            w_pcNext    = r_pc + 7'd1;
            w_stateNext = FETCH;
          end
        end
      end

      HALT: begin
        w_stateNext = HALT;
      end

      default: begin
        w_stateNext = FETCH;
      end
    endcase
  end

  // State registers. Reset abandons whatever is in flight, including an
  // instruction currently issued in EXEC, and restarts fetching at address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FETCH;
      r_pc      <= 7'd0;
      r_ir      <= 20'd0;
      r_irValid <= 1'b0;
      r_halted  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_pc      <= w_pcNext;
      r_ir      <= w_irNext;
      r_irValid <= w_irValidNext;
      r_halted  <= w_haltedNext;
      r_fault   <= w_faultNext;
    end
  end

  assign PC       = r_pc;
  assign ir_out   = r_ir;
  assign ir_valid = r_irValid;
  assign halted   = r_halted;
  assign fault    = r_fault;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
//   Bench for fetch_ctrl. A small program is placed in a modelled synchronous
//   RAM; a reference interpreter walks that program to predict every issued
//   instruction and the final stopping point, pushing the predictions into a
//   queue. A monitor pops and compares whenever the DUT issues an instruction
//   or stops. A responder process plays the datapath's exec_done.
module tb_fetch_ctrl;

  localparam int PC_MAX = 44;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] instrIn;
  logic        zFlag;
  logic        execDone;
  logic [6:0]  pcOut;
  logic [19:0] irOut;
  logic        irValid;
  logic        halted;
  logic        fault;

  typedef struct {
    int          kind;
    int          pc;
    logic [19:0] ir;
  } sbEntry_t;

  sbEntry_t    expQ[$];
  logic [19:0] ram [0:127];
  bit          zAt [0:127];

  int          checks = 0;
  int          failures = 0;
  int          expFinalKind;
  int          expFinalPc;
  int          expIssues;
  logic [19:0] expLastIr;
  int          issueSeen;

  int          fixedDelay;
  bit          randDelay;
  bit          spurEnable;

  fetch_ctrl #(.PC_MAX(PC_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr_in  (instrIn),
    .z_flag    (zFlag),
    .exec_done (execDone),
    .PC        (pcOut),
    .ir_out    (irOut),
    .ir_valid  (irValid),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // Synchronous instruction RAM: registered read of the presented address.
  initial begin
    instrIn = '0;
    forever begin
      @(posedge clk);
      instrIn <= ram[pcOut];
    end
  end

  // Zero flag is a per-address property of the program, so the reference
  // interpreter knows what JMPZ will see at each address.
  initial begin
    zFlag = 1'b0;
    forever begin
      @(negedge clk);
      zFlag = zAt[pcOut];
    end
  end

  // Datapath stand-in: completes an issued instruction after a delay, and
  // optionally throws stray exec_done pulses while nothing is issued.
  initial begin
    int cnt;
    int curDelay;
    execDone = 1'b0;
    cnt = 0;
    curDelay = 1;
    forever begin
      @(negedge clk);
      if (rst) begin
        execDone = 1'b0;
        cnt = 0;
      end else if (irValid) begin
        cnt++;
        if (cnt == 1) curDelay = randDelay ? int'($urandom_range(1, 4)) : fixedDelay;
        execDone = (cnt == curDelay);
      end else begin
        cnt = 0;
        execDone = spurEnable && ($urandom_range(0, 2) == 0);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every issue (ir_valid rising) and every stop (halted/fault
  // rising) is matched against the next prediction in the queue.
  initial begin
    bit prevV;
    bit prevT;
    sbEntry_t e;
    prevV = 1'b0;
    prevT = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (irValid && !prevV) begin
          issueSeen++;
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_issue actual_pc=%0d actual_ir=0x%0h required=none", pcOut, irOut);
          end else begin
            e = expQ.pop_front();
            checkOutput("sb_issue_kind", 0, e.kind);
            checkOutput("sb_issue_pc", pcOut, e.pc);
            checkOutput("sb_issue_ir", irOut, e.ir);
          end
        end
        if ((halted || fault) && !prevT) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_stop actual_pc=%0d halted=%0b fault=%0b required=none", pcOut, halted, fault);
          end else begin
            e = expQ.pop_front();
            checkOutput("sb_stop_kind", {30'd0, fault, halted}, e.kind);
            checkOutput("sb_stop_pc", pcOut, e.pc);
          end
        end
      end
      prevV = irValid;
      prevT = halted || fault;
    end
  end

  // Reference interpreter: walks the program from address 0 at the level of
  // the instruction set. kind 0 = issue, 1 = halted, 2 = fault. A walk that
  // has not stopped after 40 instructions gets an END patched in at the next
  // address, so every program terminates.
  task automatic buildModel();
    int pc;
    int steps;
    int tgt;
    int endKind;
    bit done;
    logic [19:0] w;
    logic [3:0] op;
    done = 1'b0;
    pc = 0;
    endKind = 0;
    while (!done) begin
      expQ.delete();
      pc = 0;
      steps = 0;
      endKind = 0;
      expIssues = 0;
      expLastIr = '0;
      while (endKind == 0 && steps < 40) begin
        w = ram[pc];
        op = w[19:16];
        tgt = int'(w[15:10]);
        steps++;
        if (op == 4'hC || (op == 4'hB && zAt[pc])) begin
          if (tgt > PC_MAX) endKind = 2;
          else pc = tgt;
        end else if (op == 4'hB) begin
          if (pc == PC_MAX) endKind = 2;
          else pc++;
        end else if (op == 4'hE) begin
          endKind = 1;
        end else begin
          expQ.push_back('{0, pc, w});
          expIssues++;
          expLastIr = w;
          if (pc == PC_MAX) endKind = 2;
          else pc++;
        end
      end
      if (endKind == 0) ram[pc] = 20'hE0000;
      else done = 1'b1;
    end
    expQ.push_back('{endKind, pc, 20'h0});
    expFinalKind = endKind;
    expFinalPc = pc;
  endtask

  task automatic clearProgram();
    for (int i = 0; i < 128; i++) begin
      ram[i] = '0;
      zAt[i] = 1'b0;
    end
  endtask

  // Asserts reset away from any clock edge, checks the reset values before
  // any edge arrives, predicts the run, then releases reset on a falling edge.
  task automatic applyStimulus();
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst_pc", pcOut, 0);
    checkOutput("rst_ir_out", irOut, 0);
    checkOutput("rst_ir_valid", irValid, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_fault", fault, 0);
    issueSeen = 0;
    buildModel();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitPc(input string name, input int target);
    int n;
    n = 0;
    while (int'(pcOut) != target && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, pcOut, target);
  endtask

  // Waits for the sequencer to stop, then keeps clocking with stray
  // exec_done pulses to confirm the stopped state holds.
  task automatic waitTerminate(input string name);
    int n;
    bit savedSpur;
    n = 0;
    while (!(halted || fault) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!(halted || fault)) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=running required=stopped", name);
    end
    savedSpur = spurEnable;
    spurEnable = 1'b1;
    repeat (8) @(negedge clk);
    spurEnable = savedSpur;
    checkOutput({name, "_hold_pc"}, pcOut, expFinalPc);
    checkOutput({name, "_hold_halted"}, halted, (expFinalKind == 1) ? 1 : 0);
    checkOutput({name, "_hold_fault"}, fault, (expFinalKind == 2) ? 1 : 0);
    checkOutput({name, "_hold_ir_valid"}, irValid, 0);
    checkOutput({name, "_hold_ir_out"}, irOut, expLastIr);
    checkOutput({name, "_issue_count"}, issueSeen, expIssues);
    checkOutput({name, "_queue_left"}, expQ.size(), 0);
  endtask

  function automatic logic [19:0] randomWord();
    int r;
    int o;
    logic [3:0] op;
    logic [5:0] tgt;
    logic [9:0] low;
    r = $urandom_range(0, 99);
    if (r < 15) op = 4'hC;
    else if (r < 30) op = 4'hB;
    else if (r < 36) op = 4'hE;
    else begin
      o = $urandom_range(0, 12);
      op = (o < 11) ? 4'(o) : ((o == 11) ? 4'hD : 4'hF);
    end
    tgt = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, PC_MAX));
    low = 10'($urandom);
    return {op, tgt, low};
  endfunction

  initial begin
    #900000;
    $display("[TB] time limit reached, summary follows");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst = 1'b1;
    fixedDelay = 2;
    randDelay = 1'b0;
    spurEnable = 1'b0;
    issueSeen = 0;
    clearProgram();

    // Plain instruction at 0 with completion three cycles after issue.
    $display("[TB] basic issue/complete");
    clearProgram();
    ram[0] = 20'h30001;
    ram[1] = 20'hE0000;
    fixedDelay = 3;
    applyStimulus();
    @(negedge clk);
    checkOutput("basic_fetch_pc", pcOut, 0);
    checkOutput("basic_fetch_valid", irValid, 0);
    @(negedge clk);
    checkOutput("basic_exec_pc", pcOut, 0);
    checkOutput("basic_exec_valid", irValid, 1);
    checkOutput("basic_exec_ir", irOut, 20'h30001);
    repeat (2) @(negedge clk);
    checkOutput("basic_dwell_valid", irValid, 1);
    checkOutput("basic_dwell_pc", pcOut, 0);
    @(negedge clk);
    checkOutput("basic_after_done_pc", pcOut, 1);
    checkOutput("basic_after_done_valid", irValid, 0);
    waitTerminate("basic");

    // JMP 12 from address 35.
    $display("[TB] jmp");
    clearProgram();
    ram[0]  = 20'hC8C00;
    ram[35] = 20'hC3000;
    ram[12] = 20'hE0000;
    fixedDelay = 2;
    applyStimulus();
    waitPc("jmp_reach35", 35);
    @(negedge clk);
    checkOutput("jmp_latch_pc", pcOut, 35);
    @(negedge clk);
    checkOutput("jmp_target_pc", pcOut, 12);
    waitTerminate("jmp");

    // JMPZ 33 from address 20, taken and then not taken.
    for (int z = 1; z >= 0; z--) begin
      $display("[TB] jmpz z_flag=%0d", z);
      clearProgram();
      ram[0]  = 20'hC5000;
      ram[20] = 20'hB8400;
      ram[21] = 20'hE0000;
      ram[33] = 20'hE0000;
      zAt[20] = (z == 1);
      applyStimulus();
      waitPc("jmpz_reach20", 20);
      @(negedge clk);
      @(negedge clk);
      checkOutput("jmpz_next_pc", pcOut, (z == 1) ? 33 : 21);
      waitTerminate("jmpz");
    end

    // END at address 32, stray completions afterwards.
    $display("[TB] end");
    clearProgram();
    ram[0]  = 20'hC8000;
    ram[32] = 20'hE0000;
    applyStimulus();
    waitTerminate("end");

    // Completion of an instruction at the last address.
    $display("[TB] exec at last address");
    clearProgram();
    ram[0]  = 20'hCB000;
    ram[44] = 20'h12345;
    applyStimulus();
    waitTerminate("exec_last");

    // Jump beyond the valid range.
    $display("[TB] jmp out of range");
    clearProgram();
    ram[0] = 20'hCC800;
    applyStimulus();
    waitTerminate("jmp_range");

    // Reset in the middle of EXEC at address 1.
    $display("[TB] reset mid-exec");
    clearProgram();
    ram[0] = 20'h30001;
    ram[1] = 20'h12345;
    ram[2] = 20'hE0000;
    fixedDelay = 2;
    applyStimulus();
    waitPc("midrst_reach1", 1);
    fixedDelay = 1000;
    begin
      int n;
      n = 0;
      while (!irValid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("midrst_exec_valid", irValid, 1);
    checkOutput("midrst_exec_pc", pcOut, 1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid_drop", irValid, 0);
    checkOutput("midrst_pc_zero", pcOut, 0);
    checkOutput("midrst_ir_zero", irOut, 0);
    fixedDelay = 2;
    issueSeen = 0;
    buildModel();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_refetch_pc", pcOut, 0);
    waitTerminate("midrst");

    // Randomized programs with random completion delays and stray pulses.
    $display("[TB] random programs");
    randDelay = 1'b1;
    spurEnable = 1'b1;
    for (int t = 0; t < 30; t++) begin
      clearProgram();
      for (int a = 0; a < 64; a++) begin
        ram[a] = randomWord();
        zAt[a] = 1'($urandom_range(0, 1));
      end
      applyStimulus();
      waitTerminate("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
